// File: rtl/grouped_update_sequencer_if.sv
// rtl/grouped_update_sequencer_if.sv - control/config/enable bundle for the grouped update sequencer
interface grouped_update_sequencer_if #(
  parameter int N_PBITS  = 2023,
  parameter int N_GROUPS = 5,
  parameter int GROUP_W  = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  parameter int HOLD_W   = 8,
  parameter int SWEEP_W  = 16
);
  logic               mask_we;
  logic [GROUP_W-1:0] mask_addr;
  logic [N_PBITS-1:0] mask_wdata;
  logic               start;
  logic               stop;
  logic [HOLD_W-1:0]  hold_cycles;
  logic [HOLD_W-1:0]  gap_cycles;
  logic [SWEEP_W-1:0] num_sweeps;
  logic [N_PBITS-1:0] pbit_en;
  logic [GROUP_W-1:0] group_idx;
  logic [SWEEP_W-1:0] sweep_cnt;
  logic               busy;
  logic               sweep_done;
  logic               done;

  modport master (
    output mask_we, mask_addr, mask_wdata, start, stop,
           hold_cycles, gap_cycles, num_sweeps,
    input  pbit_en, group_idx, sweep_cnt, busy, sweep_done, done
  );

  modport slave (
    input  mask_we, mask_addr, mask_wdata, start, stop,
           hold_cycles, gap_cycles, num_sweeps,
    output pbit_en, group_idx, sweep_cnt, busy, sweep_done, done
  );
endinterface

// File: rtl/grouped_update_sequencer.sv
// rtl/grouped_update_sequencer.sv - steps colour-group enable masks onto the p-bit array
// Each group's mask is held for hold cycles, optionally followed by an all-off gap.
module grouped_update_sequencer #(
  parameter int N_PBITS  = 2023,
  parameter int N_GROUPS = 5,
  parameter int GROUP_W  = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  parameter int HOLD_W   = 8,
  parameter int SWEEP_W  = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  grouped_update_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP, S_DONE} state_t;

  state_t             r_state, w_state_nx;
  logic [HOLD_W-1:0]  r_hold, r_gap, r_cnt, w_cnt_nx;
  logic [SWEEP_W-1:0] r_nsweeps, r_sweep, w_sweep_nx, w_sweep_inc;
  logic [GROUP_W-1:0] r_group, w_group_nx;
  logic [N_PBITS-1:0] r_mask [N_GROUPS];
  logic [N_PBITS-1:0] r_pbit_en, w_pbit_nx;
  logic               r_busy, r_sweep_done, r_done;
  logic               w_adv, w_sweep_pulse, w_latch;

  always_comb begin
    w_state_nx    = r_state;
    w_group_nx    = r_group;
    w_sweep_nx    = r_sweep;
    w_sweep_inc   = r_sweep + SWEEP_W'(1);
    w_cnt_nx      = '0;
    w_adv         = 1'b0;
    w_sweep_pulse = 1'b0;
    w_latch       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_latch    = 1'b1;
          w_state_nx = S_ACTIVE;
          w_group_nx = '0;
          w_sweep_nx = '0;
        end
      end
      S_ACTIVE: begin
        w_cnt_nx = r_cnt + HOLD_W'(1);
        if (r_cnt == r_hold - HOLD_W'(1)) begin
          w_cnt_nx = '0;
          if (r_gap != '0) w_state_nx = S_GAP;
          else             w_adv      = 1'b1;
        end
      end
      S_GAP: begin
        w_cnt_nx = r_cnt + HOLD_W'(1);
        if (r_cnt == r_gap - HOLD_W'(1)) begin
          w_cnt_nx = '0;
          w_adv    = 1'b1;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase

    if (w_adv) begin
      if (r_group == GROUP_W'(N_GROUPS - 1)) begin
        w_sweep_nx    = w_sweep_inc;
        w_sweep_pulse = 1'b1;
        if (r_nsweeps != '0 && w_sweep_inc == r_nsweeps) begin
          w_state_nx = S_DONE;
        end else begin
          w_group_nx = '0;
          w_state_nx = S_ACTIVE;
        end
      end else begin
        w_group_nx = r_group + GROUP_W'(1);
        w_state_nx = S_ACTIVE;
      end
    end

    // Abort overrides any advance, so a stop on the final cycle never yields done.
    if (bus.stop && r_state != S_IDLE) begin
      w_state_nx    = S_IDLE;
      w_group_nx    = r_group;
      w_sweep_nx    = r_sweep;
      w_sweep_pulse = 1'b0;
      w_cnt_nx      = '0;
    end

    w_pbit_nx = (w_state_nx == S_ACTIVE) ? r_mask[w_group_nx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_gap        <= '0;
      r_nsweeps    <= '0;
      r_cnt        <= '0;
      r_group      <= '0;
      r_sweep      <= '0;
      r_pbit_en    <= '0;
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_group      <= w_group_nx;
      r_sweep      <= w_sweep_nx;
      r_pbit_en    <= w_pbit_nx;
      r_busy       <= (w_state_nx == S_ACTIVE) || (w_state_nx == S_GAP);
      r_sweep_done <= w_sweep_pulse;
      r_done       <= (w_state_nx == S_DONE);
      if (w_latch) begin
        r_hold    <= (bus.hold_cycles == '0) ? HOLD_W'(1) : bus.hold_cycles;
        r_gap     <= bus.gap_cycles;
        r_nsweeps <= bus.num_sweeps;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < N_GROUPS; g++) r_mask[g] <= '0;
    end else if (bus.mask_we && (32'(bus.mask_addr) < N_GROUPS)) begin
      r_mask[bus.mask_addr] <= bus.mask_wdata;
    end
  end

  assign bus.pbit_en    = r_pbit_en;
  assign bus.group_idx  = r_group;
  assign bus.sweep_cnt  = r_sweep;
  assign bus.busy       = r_busy;
  assign bus.sweep_done = r_sweep_done;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_grouped_update_sequencer.sv
// tb/tb_grouped_update_sequencer.sv - directed and randomized checks of the grouped update sequencer
module tb_grouped_update_sequencer;
  localparam int NP = 16;
  localparam int NG = 5;
  localparam int GW = 3;
  localparam int HW = 8;
  localparam int SW = 2;

  logic clk;
  logic rst_n;

  grouped_update_sequencer_if #(.N_PBITS(NP), .N_GROUPS(NG), .GROUP_W(GW),
                                .HOLD_W(HW), .SWEEP_W(SW)) bus_if ();

  grouped_update_sequencer #(.N_PBITS(NP), .N_GROUPS(NG), .GROUP_W(GW),
                             .HOLD_W(HW), .SWEEP_W(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [NP-1:0] mdl_mask [NG];

  typedef struct {
    bit act;
    int grp;
    int sw;
    bit busy;
    bit sd;
    bit dn;
  } exp_t;
  exp_t q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pbit_en"}, 32'(bus_if.pbit_en), 0);
    chk({tag, ".group_idx"}, 32'(bus_if.group_idx), 0);
    chk({tag, ".sweep_cnt"}, 32'(bus_if.sweep_cnt), 0);
    chk({tag, ".busy"}, 32'(bus_if.busy), 0);
    chk({tag, ".sweep_done"}, 32'(bus_if.sweep_done), 0);
    chk({tag, ".done"}, 32'(bus_if.done), 0);
  endtask

  // Expected cycle-by-cycle trace after an accepted start, from the sweep rules.
  task automatic build(input int h, input int gp, input int ns, input int nsw);
    exp_t e;
    int heff;
    heff = (h == 0) ? 1 : h;
    q.delete();
    for (int s = 0; s < nsw; s++) begin
      for (int g = 0; g < NG; g++) begin
        for (int k = 0; k < heff + gp; k++) begin
          e.act  = (k < heff);
          e.grp  = g;
          e.sw   = s % (1 << SW);
          e.busy = 1'b1;
          e.sd   = (s > 0 && g == 0 && k == 0);
          e.dn   = 1'b0;
          q.push_back(e);
        end
      end
    end
    if (ns != 0) begin
      e.act = 1'b0; e.grp = NG - 1; e.sw = ns % (1 << SW);
      e.busy = 1'b0; e.sd = 1'b1; e.dn = 1'b1;
      q.push_back(e);
      e.sd = 1'b0; e.dn = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic wr_mask(input int a, input logic [NP-1:0] d);
    bus_if.mask_we    = 1'b1;
    bus_if.mask_addr  = GW'(a);
    bus_if.mask_wdata = d;
    tick();
    bus_if.mask_we = 1'b0;
    if (a < NG) mdl_mask[a] = d;
  endtask

  task automatic run(input int h, input int gp, input int ns, input int ncyc,
                     input int wr_at, input int wr_addr, input logic [NP-1:0] wr_data,
                     input int st_at, input int stop_at);
    exp_t e;
    bit pend;
    pend = 1'b0;
    bus_if.hold_cycles = HW'(h);
    bus_if.gap_cycles  = HW'(gp);
    bus_if.num_sweeps  = SW'(ns);
    bus_if.start       = 1'b1;
    tick();
    bus_if.start       = 1'b0;
    bus_if.hold_cycles = HW'($urandom_range(0, 255));
    bus_if.gap_cycles  = HW'($urandom_range(0, 255));
    bus_if.num_sweeps  = SW'($urandom_range(0, 3));
    for (int i = 0; i < ncyc; i++) begin
      e = q[i];
      chk($sformatf("pbit_en[%0d]", i), 32'(bus_if.pbit_en), e.act ? 32'(mdl_mask[e.grp]) : 0);
      chk($sformatf("group_idx[%0d]", i), 32'(bus_if.group_idx), 32'(e.grp));
      chk($sformatf("sweep_cnt[%0d]", i), 32'(bus_if.sweep_cnt), 32'(e.sw));
      chk($sformatf("busy[%0d]", i), 32'(bus_if.busy), 32'(e.busy));
      chk($sformatf("sweep_done[%0d]", i), 32'(bus_if.sweep_done), 32'(e.sd));
      chk($sformatf("done[%0d]", i), 32'(bus_if.done), 32'(e.dn));
      if (pend) begin
        if (wr_addr < NG) mdl_mask[wr_addr] = wr_data;
        pend = 1'b0;
      end
      if (i == wr_at) begin
        bus_if.mask_we    = 1'b1;
        bus_if.mask_addr  = GW'(wr_addr);
        bus_if.mask_wdata = wr_data;
        pend = 1'b1;
      end
      if (i == st_at) bus_if.start = 1'b1;
      if (i == stop_at) bus_if.stop = 1'b1;
      tick();
      bus_if.mask_we = 1'b0;
      bus_if.start   = 1'b0;
      bus_if.stop    = 1'b0;
    end
  endtask

  initial begin
    int h, gp, ns;
    rst_n              = 1'b0;
    bus_if.mask_we     = 1'b0;
    bus_if.mask_addr   = '0;
    bus_if.mask_wdata  = '0;
    bus_if.start       = 1'b0;
    bus_if.stop        = 1'b0;
    bus_if.hold_cycles = '0;
    bus_if.gap_cycles  = '0;
    bus_if.num_sweeps  = '0;
    for (int g = 0; g < NG; g++) mdl_mask[g] = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // One-hot masks, hold 2, single sweep
    for (int g = 0; g < NG; g++) wr_mask(g, NP'(1) << g);
    build(2, 0, 1, 1);
    run(2, 0, 1, q.size(), -1, 0, '0, -1, -1);

    // Gap between groups
    build(1, 2, 1, 1);
    run(1, 2, 1, q.size(), -1, 0, '0, -1, -1);

    // Randomized masks and timing
    repeat (4) begin
      for (int g = 0; g < NG; g++) wr_mask(g, NP'($urandom));
      h  = $urandom_range(0, 3);
      gp = $urandom_range(0, 2);
      ns = $urandom_range(1, 3);
      build(h, gp, ns, ns);
      run(h, gp, ns, q.size(), -1, 0, '0, -1, -1);
    end

    // Live write to the active group, plus a start while busy
    build(3, 0, 1, 1);
    run(3, 0, 1, q.size(), 3, 1, NP'($urandom), 7, -1);

    // Out-of-range write is ignored, start while busy ignored
    build(1, 1, 1, 1);
    run(1, 1, 1, q.size(), 2, 7, NP'($urandom), 4, -1);

    // Stop during group 2 of sweep 3
    build(1, 0, 0, 3);
    run(1, 0, 0, 13, -1, 0, '0, -1, 12);
    chk("stop.pbit_en", 32'(bus_if.pbit_en), 0);
    chk("stop.busy", 32'(bus_if.busy), 0);
    chk("stop.sweep_cnt", 32'(bus_if.sweep_cnt), 2);
    chk("stop.done", 32'(bus_if.done), 0);
    repeat (3) begin
      tick();
      chk("stop.done_after", 32'(bus_if.done), 0);
      chk("stop.busy_after", 32'(bus_if.busy), 0);
    end

    // Free-run with hold 0 (as 1): sweep_cnt wraps mod 4
    build(0, 0, 0, 6);
    run(0, 0, 0, 26, -1, 0, '0, -1, 25);
    chk("wrap.busy_after_stop", 32'(bus_if.busy), 0);
    chk("wrap.sweep_cnt_held", 32'(bus_if.sweep_cnt), 1);

    // Asynchronous reset mid-run
    build(1, 1, 2, 2);
    run(1, 1, 2, 4, -1, 0, '0, -1, -1);
    rst_n = 1'b0;
    #2;
    chk_all_zero("async_reset");
    for (int g = 0; g < NG; g++) mdl_mask[g] = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    build(1, 0, 1, 1);
    run(1, 0, 1, q.size(), -1, 0, '0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
